// File: rtl/rx_frame_collector.sv
// rx_frame_collector: captures one rx_interface frame into a byte buffer
// and holds it, with length/last-bits/error/overflow, until acknowledged.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   soc, eoc            frame start / end strobes
//   data, data_bits     received byte and valid bits on final byte (0 = 8)
//   data_valid, error   byte qualifier, Rx error strobe
//   frame_ready         level, a completed frame is held
//   frame_len           bytes stored (including a partial final byte)
//   frame_last_bits     bits in final byte (0 = full)
//   frame_error         error seen anywhere in the frame
//   frame_overflow      more than MAX_BYTES bytes were offered
//   frame_dropped       1-cycle pulse, SOC arrived while holding a frame
//   frame_ack           1-cycle pulse, releases the held frame
//   rd_addr, rd_data    buffer read port, 1-cycle latency
module rx_frame_collector #(
    parameter int MAX_BYTES = 32,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soc,
    input  logic             eoc,
    input  logic [7:0]       data,
    input  logic [2:0]       data_bits,
    input  logic             data_valid,
    input  logic             error,
    output logic             frame_ready,
    output logic [LEN_W-1:0] frame_len,
    output logic [2:0]       frame_last_bits,
    output logic             frame_error,
    output logic             frame_overflow,
    output logic             frame_dropped,
    input  logic             frame_ack,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data
);

    localparam int AW = $clog2(MAX_BYTES);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [2:0]       lb, lb_n;
    logic             er, er_n;
    logic             ov, ov_n;
    logic             wr_en;
    logic             drop_n;
    logic             done;

    logic [7:0] mem [MAX_BYTES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            lb    <= '0;
            er    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lb    <= lb_n;
            er    <= er_n;
            ov    <= ov_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lb_n    = lb;
        er_n    = er;
        ov_n    = ov;
        wr_en   = 1'b0;
        drop_n  = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (soc) begin
                    cnt_n   = '0;
                    lb_n    = '0;
                    er_n    = 1'b0;
                    ov_n    = 1'b0;
                    state_n = RX;
                end
            end
            RX: begin
                if (soc) begin
                    cnt_n = '0;
                    lb_n  = '0;
                    er_n  = 1'b0;
                    ov_n  = 1'b0;
                end else begin
                    if (error) begin
                        er_n = 1'b1;
                    end
                    if (data_valid) begin
                        if (cnt < MAX_L) begin
                            wr_en = 1'b1;
                            cnt_n = cnt + 1'b1;
                        end else begin
                            ov_n = 1'b1;
                            er_n = 1'b1;
                        end
                    end
                    if (eoc) begin
                        if (data_valid) begin
                            lb_n = data_bits;
                        end
                        done    = 1'b1;
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    if (soc) begin
                        // Ack and restart in one cycle: behave as from IDLE.
                        cnt_n   = '0;
                        lb_n    = '0;
                        er_n    = 1'b0;
                        ov_n    = 1'b0;
                        state_n = RX;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (soc) begin
                    drop_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Published status is captured at EOC so it stays stable across
    // the next frame's reception until the following EOC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ready     <= 1'b0;
            frame_len       <= '0;
            frame_last_bits <= '0;
            frame_error     <= 1'b0;
            frame_overflow  <= 1'b0;
            frame_dropped   <= 1'b0;
        end else begin
            frame_ready   <= (state_n == HOLD);
            frame_dropped <= drop_n;
            if (done) begin
                frame_len       <= cnt_n;
                frame_last_bits <= lb_n;
                frame_error     <= er_n;
                frame_overflow  <= ov_n;
            end
        end
    end

    // Byte storage is not reset; cnt < MAX_BYTES bounds the write index.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cnt[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_addr < MAX_L) begin
            rd_data <= mem[rd_addr[AW-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_rx_frame_collector.sv
// tb_rx_frame_collector: table-driven frame vectors plus hand sequences
// for drop, ack+soc and reset corner cases; bytes tracked in a queue.
module tb_rx_frame_collector;

    localparam int MAX = 32;
    localparam int LW  = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          soc, eoc, data_valid, error, frame_ack;
    logic [7:0]    data;
    logic [2:0]    data_bits;
    logic          frame_ready, frame_error, frame_overflow, frame_dropped;
    logic [LW-1:0] frame_len, rd_addr;
    logic [2:0]    frame_last_bits;
    logic [7:0]    rd_data;

    rx_frame_collector #(.MAX_BYTES(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .soc(soc), .eoc(eoc), .data(data),
        .data_bits(data_bits), .data_valid(data_valid), .error(error),
        .frame_ready(frame_ready), .frame_len(frame_len),
        .frame_last_bits(frame_last_bits), .frame_error(frame_error),
        .frame_overflow(frame_overflow), .frame_dropped(frame_dropped),
        .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nmid;
        bit         fv;
        logic [2:0] fb;
        bit         epre;
        bit         eeoc;
        int         elen;
        logic [2:0] ebits;
        bit         eerr;
        bit         eovf;
    } vec_t;

    vec_t       vt[8];
    logic [7:0] pat[64];
    logic [7:0] sb[$];
    logic [7:0] last[64];
    int         nlast;
    int         tests = 0;
    int         fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill_pat();
        for (int i = 0; i < 64; i++) pat[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic run_frame(input int nmid, input bit fv,
                             input logic [2:0] fb, input bit epre,
                             input bit eeoc, input bit with_soc);
        int c;
        c = 0;
        if (with_soc) begin
            soc = 1'b1;
            tick();
            soc = 1'b0;
        end
        if (epre) begin
            error = 1'b1;
            tick();
            error = 1'b0;
        end
        for (int i = 0; i < nmid; i++) begin
            data_valid = 1'b1;
            data = pat[i];
            if (c < MAX) begin
                sb.push_back(pat[i]);
                c++;
            end
            tick();
        end
        data_valid = 1'b0;
        chk("ready_before_eoc", frame_ready, 0);
        eoc = 1'b1;
        data_valid = fv;
        data = pat[nmid];
        data_bits = fb;
        error = eeoc;
        if (fv && c < MAX) sb.push_back(pat[nmid]);
        tick();
        eoc = 1'b0;
        data_valid = 1'b0;
        error = 1'b0;
        data_bits = 3'd0;
        chk("ready_after_eoc", frame_ready, 1);
    endtask

    task automatic check_frame(input int elen, input logic [2:0] ebits,
                               input bit eerr, input bit eovf);
        int n;
        chk("frame_len", frame_len, elen);
        chk("frame_last_bits", frame_last_bits, ebits);
        chk("frame_error", frame_error, eerr);
        chk("frame_overflow", frame_overflow, eovf);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            rd_addr = LW'(i);
            tick();
            last[i] = sb.pop_front();
            chk($sformatf("rd_data[%0d]", i), rd_data, last[i]);
        end
        nlast = n;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ready_after_ack", frame_ready, 0);
    endtask

    initial begin
        vt[0] = '{3, 1'b0, 3'd0, 1'b0, 1'b0, 3, 3'd0, 1'b0, 1'b0};
        vt[1] = '{2, 1'b1, 3'd7, 1'b0, 1'b0, 3, 3'd7, 1'b0, 1'b0};
        vt[2] = '{3, 1'b0, 3'd0, 1'b1, 1'b0, 3, 3'd0, 1'b1, 1'b0};
        vt[3] = '{2, 1'b1, 3'd2, 1'b0, 1'b1, 3, 3'd2, 1'b1, 1'b0};
        vt[4] = '{MAX + 2, 1'b0, 3'd0, 1'b0, 1'b0, MAX, 3'd0, 1'b1, 1'b1};
        vt[5] = '{MAX - 1, 1'b1, 3'd3, 1'b0, 1'b0, MAX, 3'd3, 1'b0, 1'b0};
        vt[6] = '{MAX, 1'b1, 3'd5, 1'b0, 1'b0, MAX, 3'd5, 1'b1, 1'b1};
        vt[7] = '{0, 1'b0, 3'd0, 1'b0, 1'b0, 0, 3'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        soc = 0; eoc = 0; data_valid = 0; error = 0; frame_ack = 0;
        data = '0; data_bits = '0; rd_addr = '0;
        tick();
        tick();
        chk("rst_ready", frame_ready, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_dropped", frame_dropped, 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) begin
            fill_pat();
            if (k == 0) begin
                pat[0] = 8'h26; pat[1] = 8'h52; pat[2] = 8'h93;
            end
            if (k == 1) pat[2] = 8'h26;
            run_frame(vt[k].nmid, vt[k].fv, vt[k].fb, vt[k].epre,
                      vt[k].eeoc, 1'b1);
            check_frame(vt[k].elen, vt[k].ebits, vt[k].eerr, vt[k].eovf);
            ack();
            tick();
        end

        // Drop while holding.
        fill_pat();
        run_frame(2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        check_frame(2, 3'd0, 1'b0, 1'b0);
        soc = 1'b1;
        tick();
        soc = 1'b0;
        chk("drop_pulse", frame_dropped, 1);
        data_valid = 1'b1;
        data = 8'hAA;
        tick();
        chk("drop_pulse_end", frame_dropped, 0);
        data = 8'hBB;
        error = 1'b1;
        tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0; data_valid = 1'b0; error = 1'b0;
        chk("drop_ready", frame_ready, 1);
        chk("drop_len", frame_len, 2);
        chk("drop_err", frame_error, 0);
        for (int i = 0; i < nlast; i++) begin
            rd_addr = LW'(i);
            tick();
            chk($sformatf("drop_rd[%0d]", i), rd_data, last[i]);
        end
        ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_idle_ignored", frame_ready, 0);

        // SOC coincident with ack.
        fill_pat();
        run_frame(1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        check_frame(1, 3'd0, 1'b0, 1'b0);
        fill_pat();
        soc = 1'b1;
        frame_ack = 1'b1;
        tick();
        soc = 1'b0;
        frame_ack = 1'b0;
        chk("socack_no_drop", frame_dropped, 0);
        chk("socack_ready_low", frame_ready, 0);
        run_frame(2, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        check_frame(3, 3'd4, 1'b0, 1'b0);
        ack();

        // Reset mid-frame after an errored frame left status set.
        fill_pat();
        run_frame(2, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        check_frame(2, 3'd0, 1'b1, 1'b0);
        ack();
        soc = 1'b1;
        tick();
        soc = 1'b0;
        data_valid = 1'b1;
        data = 8'h11;
        tick();
        data = 8'h22;
        tick();
        data_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("mrst_ready", frame_ready, 0);
        chk("mrst_len", frame_len, 0);
        chk("mrst_bits", frame_last_bits, 0);
        chk("mrst_err", frame_error, 0);
        chk("mrst_ovf", frame_overflow, 0);
        chk("mrst_drop", frame_dropped, 0);
        chk("mrst_rd", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mrst_no_ready", frame_ready, 0);
        fill_pat();
        run_frame(1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        check_frame(1, 3'd0, 1'b0, 1'b0);
        ack();
        run_frame(0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        check_frame(0, 3'd0, 1'b0, 1'b0);
        ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_frame_collector.md
# rx_frame_collector

Synthesizable consumer of the byte-mode `rx_interface`. It sits between the Rx deframer and the protocol state machine. It captures one frame at a time into an internal byte buffer and records the frame length, the bit count of the final partial byte and any error/overflow status. The finished frame is held for the downstream logic until that logic acknowledges it.

## Interface
Parameters:
- `MAX_BYTES`, 32, buffer depth in bytes (≥2)
- `LEN_W`, `$clog2(MAX_BYTES+1)`, width of the length output (derived, do not override)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `soc`  in  1  start of frame strobe (rx_interface)
- `eoc`  in  1  end of frame strobe (rx_interface)
- `data`  in  8  received byte (rx_interface)
- `data_bits`  in  3  valid bits in `data`; 0 means 8 (rx_interface)
- `data_valid`  in  1  `data` qualifier (rx_interface)
- `error`  in  1  Rx error strobe (rx_interface)
- `frame_ready`  out  1  level; a completed frame is held
- `frame_len`  out  LEN_W  number of bytes stored, including any partial byte
- `frame_last_bits`  out  3  bits in the final byte; 0 means full byte
- `frame_error`  out  1  error seen anywhere in the frame
- `frame_overflow`  out  1  more than MAX_BYTES bytes were offered
- `frame_dropped`  out  1  one-cycle pulse; a SOC arrived while the block was in HOLD
- `frame_ack`  in  1  one-cycle pulse; frees the held frame
- `rd_addr`  in  LEN_W  buffer read address
- `rd_data`  out  8  registered `buf[rd_addr]`

## Operation
- FSM states: IDLE, RX, HOLD. Reset state is IDLE.
- IDLE:
  - `soc` clears the byte count, last_bits, error and overflow, then moves to RX.
  - All other inputs are ignored.
- RX, `data_valid` without `eoc`:
  - If count < MAX_BYTES, write `data` to `buf[count]` and increment count.
  - Otherwise, set overflow and error and discard the byte. Count saturates at MAX_BYTES.
- RX, `error`: sets the error flag. Reception continues until `eoc`.
- RX, `eoc`:
  - If `data_valid` is asserted in the same cycle, store the final byte under the normal full/overflow rule and latch `data_bits` into last_bits.
  - If `error` is asserted in the same cycle, set the error flag.
  - Move to HOLD.
- RX, `soc`: restarts the frame (count and flags cleared), stays in RX. `soc` has priority over `data_valid`/`eoc` in the same cycle.
- HOLD:
  - `frame_ready`=1. `frame_len`, `frame_last_bits`, `frame_error`, `frame_overflow` and the buffer contents are stable.
  - `frame_ack` returns to IDLE.
  - `soc` without `frame_ack` pulses `frame_dropped` for one cycle and the incoming frame is ignored entirely. Its `data_valid`/`eoc` are ignored until the next IDLE.
  - `soc` and `frame_ack` in the same cycle: ack first, then start RX in that cycle, as from IDLE. No drop.
- `frame_ack` outside HOLD is ignored.
- A frame with no data (`soc` then `eoc`) is legal: `frame_len`=0, `frame_last_bits`=0.
- `data_bits` is only used on the `eoc` cycle. Mid-frame bytes are always treated as full.

## Timing
- Reset values: `frame_ready`=0, `frame_len`=0, `frame_last_bits`=0, `frame_error`=0, `frame_overflow`=0, `frame_dropped`=0, `rd_data`=0. Buffer contents are not reset.
- `frame_ready` rises in the cycle after `eoc` is sampled. It falls in the cycle after `frame_ack` is sampled.
- Status outputs are registers. They are valid whenever `frame_ready`=1 and hold their last values otherwise.
- `rd_data` has 1-cycle latency from `rd_addr`. For `rd_addr` ≥ MAX_BYTES the value is don't-care.
- Any `rst_n` assertion returns the block to IDLE immediately, mid-frame or in HOLD. The partial frame is lost and no `frame_ready` is produced.
- No combinational path from inputs to outputs.

## Test plan
- 3-byte frame 0x26,0x52,0x93 with `eoc` alone -> `frame_ready` one cycle after `eoc`; `frame_len`=3; `frame_last_bits`=0; flags 0; `rd_addr` 0..2 returns the bytes with 1-cycle latency.
- 2 full bytes, then `eoc` with `data_valid`, `data_bits`=7, `data`=0x26 -> `frame_len`=3, `frame_last_bits`=7, `buf[2]`=0x26.
- `error` before byte 1, and separately `error` coincident with `eoc` -> `frame_error`=1 in both cases, other fields correct, frame still delivered.
- MAX_BYTES+2 bytes -> `frame_len`=MAX_BYTES, `frame_overflow`=1, `frame_error`=1, the first MAX_BYTES bytes intact.
- Frame held, second `soc`+bytes+`eoc` without ack -> one `frame_dropped` pulse, held frame unchanged. Then `frame_ack` -> `frame_ready`=0. Then `soc` coincident with `frame_ack` on a later held frame -> no drop, new frame captured.
- `rst_n` low mid-frame after 2 bytes -> all outputs at reset values. Next full frame of 1 byte -> `frame_len`=1. Empty frame (`soc`,`eoc`) -> `frame_len`=0, `frame_ready`=1.
